// File: rtl/booth_r4_seq_mac.sv
// booth_r4_seq_mac: sequential radix-4 Booth signed multiply-accumulate, one B digit per clock,
// valid/ready on both sides, optional zeroing of the low product columns.
module booth_r4_seq_mac #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16,
    parameter int ACC_W   = 40,
    parameter int APP_LSB = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_A-1:0] in_a,
    input  logic [WIDTH_B-1:0] in_b,
    input  logic               in_acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH_B);
    localparam logic [CW-1:0] LAST = CW'(WIDTH_B / 2 - 1);
    localparam logic [ACC_W-1:0] MASK = ~((ACC_W'(1) << APP_LSB) - ACC_W'(1));
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic accept;
    logic [CW-1:0] cnt;
    logic [WIDTH_B:0] b_sh;
    logic [ACC_W-1:0] m, mag, pp, acc;
    logic [2:0] t;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        accept    = in_valid && in_ready;
        state_nxt = accept ? RUN :
                    (state == RUN && cnt == LAST) ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
    end
    // b_sh[2:0] is the current Booth triplet {b[2i+1], b[2i], b[2i-1]}; m is A pre-shifted by 2i
    assign t = b_sh[2:0];
    always_comb begin
        mag = (t == 3'b011 || t == 3'b100) ? m << 1 : (t == 3'b000 || t == 3'b111) ? '0 : m;
        pp  = (t[2] ? -mag : mag) & MASK;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            cnt  <= '0;
            b_sh <= '0;
            m    <= '0;
        end else if (accept) begin
            acc  <= in_acc ? acc : '0;
            cnt  <= '0;
            b_sh <= {in_b, 1'b0};
            m    <= {{(ACC_W - WIDTH_A){in_a[WIDTH_A-1]}}, in_a};
        end else if (state == RUN) begin
            acc  <= acc + pp;
            cnt  <= cnt + CW'(1);
            b_sh <= b_sh >> 2;
            m    <= m << 2;
        end
    end
    assign out_data = acc;
endmodule
